// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 4;
  localparam int FIFO_DEF_DEPTH = 8;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Number of bits needed to address 'value' entries (value >= 2).
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer side of the FIFO: write/read handshakes, data and status.
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH
);
  localparam int ADDR_W = clog2(DEPTH);

  logic [WIDTH-1:0] data_in;
  logic             write;
  logic             read;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic [ADDR_W:0]  count;
  logic             overflow;
  logic             underflow;

  modport master (
    output data_in, write, read, clr_err,
    input  data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  data_in, write, read, clr_err,
    output data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port, no reset.
module fifo_ram #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with threshold flags, occupancy count,
// sticky error flags and optional first-word-fall-through read mode.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEF_WIDTH,
  parameter int DEPTH    = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FIFO_STD
) (
  input logic              clk,
  input logic              reset,
  fifo_sync_param_if.slave bus
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  logic [ADDR_W:0]  wr_ptr, rd_ptr, count_q, count_next;
  logic             empty_q, full_q, af_q, ae_q, ovf_q, unf_q;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] ram_rdata;

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign wr_ok = bus.write && (!full_q || bus.read);
  assign rd_ok = bus.read && !empty_q;

  always_comb begin
    count_next = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_q + ONE;
      2'b01:   count_next = count_q - ONE;
      default: count_next = count_q;
    endcase
  end

  // Flags are registered from the next count so they always agree with count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ONE;
      if (rd_ok) rd_ptr <= rd_ptr + ONE;
      count_q <= count_next;
      empty_q <= (count_next == '0);
      full_q  <= (count_next == (ADDR_W+1)'(DEPTH));
      af_q    <= (int'(count_next) >= AF_LEVEL);
      ae_q    <= (int'(count_next) <= AE_LEVEL);
      ovf_q   <= (ovf_q && !bus.clr_err) || (bus.write && full_q && !bus.read);
      unf_q   <= (unf_q && !bus.clr_err) || (bus.read && empty_q);
    end
  end

  fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      assign bus.data_out = empty_q ? '0 : ram_rdata;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          dout_q <= '0;
        end else if (rd_ok) begin
          dout_q <= ram_rdata;
        end
      end

      assign bus.data_out = dout_q;
    end
  endgenerate

  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous FIFO, successor to the fixed 4-bit/8-deep fifo_sync.
- Generalised data width and depth.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, and an optional first-word-fall-through (FWFT) read mode.
- Sits between same-clock producer/consumer blocks as the standard buffering primitive.

Parameters:
- WIDTH, 4, data word width in bits (≥1).
- DEPTH, 8, number of entries; power of 2, ≥2.
- AF_LEVEL, DEPTH-2, almost_full asserted when count ≥ AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when count ≤ AE_LEVEL.
- FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word visible on data_out whenever !empty.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  write data.
- write  in  1  write request.
- read  in  1  read request.
- clr_err  in  1  synchronous clear of overflow/underflow.
- data_out  out  WIDTH  read data.
- empty  out  1  no valid entries.
- full  out  1  DEPTH entries held.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  ADDR_W+1  occupancy 0..DEPTH, where ADDR_W = clog2(DEPTH).
- overflow  out  1  sticky: write attempted while full and not accepted.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- **Reset** (reset=0, asynchronous assert, synchronous-to-clk deassert tolerated):
  - rd/wr pointers = 0, count = 0, data_out = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0.
  - Memory contents are not reset.
- **Pointers**: ADDR_W+1 bits; the MSB is the wrap bit. empty = (ptrs equal); full = (addr bits equal, wrap bits differ). Pointers wrap DEPTH-1 → 0 naturally.
- **Accept rules**:
  - wr_ok = write && (!full || read)
  - rd_ok = read && !empty
  - Full with write+read: both accepted, count unchanged, the new word goes to the freed slot.
  - Empty with write+read: write accepted, read rejected, underflow set; the word is not bypassed.
- **count**: +1 on wr_ok only, −1 on rd_ok only, unchanged otherwise. Flags are registered and consistent with count in the same cycle.
- **FWFT=0**: on rd_ok, data_out <= mem[rd_ptr] at that edge (1-cycle latency). Otherwise data_out holds its last value.
- **FWFT=1**: data_out = mem[rd_ptr] combinationally whenever !empty, and 0 when empty. rd_ok advances to the next entry. A word written into an empty FIFO appears on data_out one cycle after its write edge.
- **Error flags**:
  - overflow set on write && full && !read.
  - underflow set on read && empty.
  - Flags hold until clr_err=1 or reset. If clr_err and a new error occur in the same cycle, the flag stays 1.
- **Mid-operation reset**: all state is discarded immediately; the first write after release lands in slot 0.
- No X propagation: data_out never reads unwritten memory in FWFT=0 when read is gated by empty.

Decomposition:
- Package fifo_pkg:
  - clog2 constant function.
  - Default WIDTH/DEPTH constants.
  - FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1).
- Sub-module fifo_ram: DEPTH×WIDTH dual-port array with one synchronous write port and one asynchronous read port. No reset.
- Top-level fifo_sync_param holds pointers, count, flags and the output register.

Test Plan:
1. Reset low 5 ns, release; FWFT=0 → empty=1, full=0, count=0, data_out=0, overflow=underflow=0.
2. Write 1,2,3,5,5,6,7,8 on consecutive cycles:
   - count steps 1..8.
   - almost_full rises at count=6.
   - full=1 after the 8th write.
   - A 9th write of 9 is dropped: overflow=1, count stays 8.
3. Read 8 times:
   - data_out sequence 1,2,3,5,5,6,7,8, each one cycle after its read.
   - almost_empty rises at count=2; empty=1 after the last read.
   - A 9th read sets underflow=1 and data_out holds 8.
4. Fill to full, assert write+read with data_in=A for 3 cycles → count stays 8, full stays 1, overflow not set. A subsequent full drain yields A,A,A as the last three words.
5. Write 4 words, assert reset mid-burst → count=0, empty=1 instantly. Post-release, write B and read → data_out=B (pointer restarted at 0). Pulse clr_err → error flags 0.
6. FWFT=1: write C into empty FIFO → data_out=C one cycle later with read low. Read once → empty=1, data_out=0. Write+read on empty → underflow=1, count=1.
